// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants for the LCD command sequencer
package lcd_pkg;

  localparam logic [2:0] CMD_WRITE    = 3'd0;
  localparam logic [2:0] CMD_UP       = 3'd1;
  localparam logic [2:0] CMD_DOWN     = 3'd2;
  localparam logic [2:0] CMD_LEFT     = 3'd3;
  localparam logic [2:0] CMD_RIGHT    = 3'd4;
  localparam logic [2:0] CMD_AVERAGE  = 3'd5;
  localparam logic [2:0] CMD_MIRROR_X = 3'd6;
  localparam logic [2:0] CMD_MIRROR_Y = 3'd7;

  localparam int REP_MSB = 7;
  localparam int REP_LSB = 3;
  localparam int CMD_MSB = 2;
  localparam int CMD_LSB = 0;

  localparam logic [2:0] WAIT_LOAD = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] GAP       = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous command FIFO with registered storage
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - paces queued host commands into the LCD image controller
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [7:0]             req_data,
  output logic                   req_ready,
  input  logic                   lcd_busy,
  input  logic                   lcd_done,
  output logic [2:0]             lcd_cmd,
  output logic                   lcd_cmd_valid,
  output logic                   frame_done,
  output logic                   halted,
  output logic [7:0]             issue_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [4:0]    rep_cnt_q, rep_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [7:0]    issue_cnt_q, issue_cnt_d;
  logic          frame_done_q, frame_done_d;

  logic          push, pop, full, empty, gap_last;
  logic [7:0]    head;

  assign push      = req_valid && req_ready;
  assign req_ready = !full && (state_q != HALT);
  assign gap_last  = (gap_cnt_q == GAP_LAST);

  lcd_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .data_i  (req_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    rep_cnt_d    = rep_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cmd_d        = cmd_q;
    issue_cnt_d  = issue_cnt_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      WAIT_LOAD: if (!lcd_busy) state_d = IDLE;
      IDLE: begin
        if (!empty && !lcd_busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt_q != 8'hFF) issue_cnt_d = issue_cnt_q + 8'd1;
        gap_cnt_d = '0;
        state_d   = (cmd_q == CMD_WRITE) ? WAIT_DONE : GAP;
      end
      GAP: begin
        // A pending repeat holds the gap open until busy drops; a drained one falls back to IDLE.
        if (!gap_last) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end else if (rep_cnt_q != '0 && !lcd_busy) begin
          rep_cnt_d = rep_cnt_q - 5'd1;
          state_d   = ISSUE;
        end else if (rep_cnt_q == '0 && !empty && !lcd_busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end else if (rep_cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (lcd_done) begin
          frame_done_d = 1'b1;
          state_d      = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = WAIT_LOAD;
    endcase
    if (pop) begin
      cmd_d     = head[CMD_MSB:CMD_LSB];
      rep_cnt_d = (cmd_d == CMD_WRITE) ? 5'd0 : head[REP_MSB:REP_LSB];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_LOAD;
      rep_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      cmd_q        <= '0;
      issue_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rep_cnt_q    <= rep_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cmd_q        <= cmd_d;
      issue_cnt_q  <= issue_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = (state_q == ISSUE);
  assign halted        = (state_q == HALT);
  assign issue_count   = issue_cnt_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - directed vector bench for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_data = '0;
  logic       req_ready;
  logic       lcd_busy = 1'b1;
  logic       lcd_done = 1'b0;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       frame_done;
  logic       halted;
  logic [7:0] issue_count;
  logic [3:0] fifo_level;

  lcd_cmd_sequencer #(.DEPTH(8), .GAP_CYCLES(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .frame_done    (frame_done),
    .halted        (halted),
    .issue_count   (issue_count),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       clr_mon = 1'b0;
  int         pulse_n = 0;
  int         consec = 0;
  logic       prev_v = 1'b0;
  logic [2:0] pcmd [300];
  int         pcyc [300];

  always @(negedge clk) begin
    if (clr_mon) begin
      pulse_n <= 0;
      prev_v  <= 1'b0;
    end else begin
      prev_v <= lcd_cmd_valid;
      if (lcd_cmd_valid) begin
        if (pulse_n < 300) begin
          pcmd[pulse_n] <= lcd_cmd;
          pcyc[pulse_n] <= cyc;
        end
        pulse_n <= pulse_n + 1;
        if (prev_v) consec <= consec + 1;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge clk);
    #1 clr_mon = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    lcd_done  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic to_idle();
    lcd_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic push(input logic [7:0] w, output int acc_cyc);
    int budget;
    budget    = 100;
    req_valid = 1'b1;
    req_data  = w;
    while (!req_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("push_timeout", 0, 1);
    acc_cyc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    bit         two;
    int         n0;
    int         n;
  } vec_t;

  vec_t vecs [4];

  initial begin : main
    int t0, tx, bad_cmd, bad_sp, p, d, budget;
    logic [7:0] w;
    logic [2:0] ec;

    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

  initial begin : stim
    int t0, tx, bad_cmd, bad_sp, p, budget;
    logic [7:0] w;
    logic [2:0] ec;

    vecs[0] = '{w0: 8'h1C, w1: 8'h05, two: 1'b1, n0: 4,  n: 5};
    vecs[1] = '{w0: 8'h02, w1: 8'h00, two: 1'b0, n0: 1,  n: 1};
    vecs[2] = '{w0: 8'hFF, w1: 8'h00, two: 1'b0, n0: 32, n: 32};
    vecs[3] = '{w0: 8'h3B, w1: 8'h16, two: 1'b1, n0: 8,  n: 11};

    // reset values and busy-gated first issue
    lcd_busy = 1'b1;
    do_reset();
    check("rst_req_ready", req_ready, 1);
    check("rst_lcd_cmd", lcd_cmd, 0);
    check("rst_cmd_valid", lcd_cmd_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_halted", halted, 0);
    check("rst_issue_count", issue_count, 0);
    check("rst_fifo_level", fifo_level, 0);

    push(8'h01, t0);
    repeat (69) tick();
    check("busy_no_pulse", pulse_n, 0);
    check("busy_level", fifo_level, 1);
    lcd_busy = 1'b0;
    tick();
    tick();
    check("load_valid", lcd_cmd_valid, 1);
    check("load_cmd", lcd_cmd, 1);
    tick();
    check("load_issue_count", issue_count, 1);

    // table-driven repeat expansion
    for (int v = 0; v < 4; v++) begin
      lcd_busy = 1'b1;
      do_reset();
      to_idle();
      push(vecs[v].w0, t0);
      if (vecs[v].two) push(vecs[v].w1, tx);
      repeat (80) tick();
      check($sformatf("v%0d_pulses", v), pulse_n, vecs[v].n);
      check($sformatf("v%0d_latency", v), pcyc[0] - t0, 2);
      bad_cmd = 0;
      bad_sp  = 0;
      for (int i = 0; i < vecs[v].n && i < pulse_n; i++) begin
        w  = (i < vecs[v].n0) ? vecs[v].w0 : vecs[v].w1;
        ec = w[2:0];
        if (pcmd[i] != ec) bad_cmd++;
        if (i > 0 && pcyc[i] - pcyc[i-1] != 2) bad_sp++;
      end
      check($sformatf("v%0d_cmd_errs", v), bad_cmd, 0);
      check($sformatf("v%0d_spacing_errs", v), bad_sp, 0);
      check($sformatf("v%0d_issue_count", v), issue_count, vecs[v].n);
      check($sformatf("v%0d_fifo_level", v), fifo_level, 0);
    end

    // full FIFO during WAIT_LOAD; 9th word held until first pop
    lcd_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      w = 8'((i % 7) + 1);
      push(w, tx);
    end
    check("full_ready", req_ready, 0);
    check("full_level", fifo_level, 8);
    req_valid = 1'b1;
    req_data  = 8'h02;
    repeat (5) tick();
    check("full_hold_level", fifo_level, 8);
    lcd_busy = 1'b0;
    budget = 0;
    while (!req_ready && budget < 20) begin
      tick();
      budget++;
    end
    check("full_accept_wait", budget, 2);
    tick();
    req_valid = 1'b0;
    repeat (30) tick();
    check("full_pulses", pulse_n, 9);
    bad_cmd = 0;
    for (int i = 0; i < 9; i++) begin
      ec = (i < 8) ? 3'((i % 7) + 1) : 3'd2;
      if (pcmd[i] != ec) bad_cmd++;
    end
    check("full_cmd_errs", bad_cmd, 0);
    check("full_fifo_drained", fifo_level, 0);

    // busy stall during a repeat
    lcd_busy = 1'b1;
    do_reset();
    to_idle();
    push(8'h16, t0);
    budget = 0;
    while (!lcd_cmd_valid && budget < 20) begin
      tick();
      budget++;
    end
    p = cyc;
    tick();
    lcd_busy = 1'b1;
    repeat (5) tick();
    lcd_busy = 1'b0;
    repeat (20) tick();
    check("stall_pulses", pulse_n, 3);
    check("stall_2nd_at", pcyc[1] - p, 7);
    check("stall_3rd_at", pcyc[2] - p, 9);
    check("stall_cmd", pcmd[2], 6);

    // Write ends the frame and halts
    lcd_busy = 1'b1;
    do_reset();
    to_idle();
    push(8'h38, t0);
    push(8'h01, tx);
    budget = 0;
    while (!lcd_cmd_valid && budget < 20) begin
      tick();
      budget++;
    end
    check("wr_cmd", lcd_cmd, 0);
    lcd_busy = 1'b1;
    repeat (10) tick();
    check("wr_not_halted", halted, 0);
    check("wr_no_frame_done", frame_done, 0);
    repeat (54) tick();
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    lcd_busy = 1'b0;
    check("wr_frame_done", frame_done, 1);
    check("wr_halted", halted, 1);
    check("wr_req_ready", req_ready, 0);
    tick();
    check("wr_frame_done_pulse", frame_done, 0);
    check("wr_still_halted", halted, 1);
    repeat (20) tick();
    check("wr_pulses", pulse_n, 1);
    check("wr_queued", fifo_level, 1);
    check("wr_issue_count", issue_count, 1);

    // reset mid-repeat with words queued
    lcd_busy = 1'b1;
    do_reset();
    to_idle();
    push(8'hFF, t0);
    push(8'h01, tx);
    push(8'h02, tx);
    push(8'h03, tx);
    budget = 0;
    while (pulse_n < 3 && budget < 30) begin
      tick();
      budget++;
    end
    check("mid_queued", fifo_level, 3);
    reset    = 1'b1;
    lcd_busy = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_fifo_level", fifo_level, 0);
    check("mid_issue_count", issue_count, 0);
    check("mid_cmd_valid", lcd_cmd_valid, 0);
    check("mid_req_ready", req_ready, 1);
    clear_mon();
    repeat (20) tick();
    lcd_busy = 1'b0;
    repeat (10) tick();
    check("mid_no_pulses", pulse_n, 0);

    // issue_count saturation: 8 x 32 = 256 issues
    lcd_busy = 1'b1;
    do_reset();
    to_idle();
    for (int i = 0; i < 8; i++) push(8'hF9, tx);
    repeat (540) tick();
    check("sat_pulses", pulse_n, 256);
    check("sat_issue_count", issue_count, 255);

    check("no_back_to_back", consec, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
